// File: rtl/psram_arb_pkg.sv
// rtl/psram_arb_pkg.sv - shared state encoding and reset constants for the PSRAM arbiter
package psram_arb_pkg;

  // Encoding chosen so the state value is directly the one-hot owner vector.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY0 = 2'b01,
    BUSY1 = 2'b10
  } state_t;

  // last = 1 after reset, so requester 0 wins the first conflict.
  localparam logic LAST_RST = 1'b1;

  // One-hot owner vector for a state (zero when idle).
  function automatic logic [1:0] state_grant(input state_t s);
    return s;
  endfunction

endpackage

// File: rtl/psram_arb_rr.sv
// rtl/psram_arb_rr.sv - combinational two-way round-robin pick
module psram_arb_rr (
  input  logic [1:0] valid_i,
  input  logic       last_i,
  output logic       idx_o,
  output logic       any_o
);

  // On conflict pick the requester that did not win last; otherwise the only valid one.
  always_comb begin
    any_o = |valid_i;
    if (&valid_i) begin
      idx_o = ~last_i;
    end else begin
      idx_o = valid_i[1];
    end
  end

endmodule

// File: rtl/psram_arb.sv
// rtl/psram_arb.sv - two-requester arbiter in front of a QSPI PSRAM controller (optional timeout: PSRAM_ARB_TIMEOUT_EN)
module psram_arb
  import psram_arb_pkg::*;
#(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req0_valid_i,
  input  logic [ADDR_W-1:0]   req0_addr_i,
  input  logic [DATA_W-1:0]   req0_wdata_i,
  input  logic [DATA_W/8-1:0] req0_wstrb_i,
  output logic                req0_ready_o,
  output logic [DATA_W-1:0]   req0_rdata_o,
  input  logic                req1_valid_i,
  input  logic [ADDR_W-1:0]   req1_addr_i,
  input  logic [DATA_W-1:0]   req1_wdata_i,
  input  logic [DATA_W/8-1:0] req1_wstrb_i,
  output logic                req1_ready_o,
  output logic [DATA_W-1:0]   req1_rdata_o,
  output logic                mem_valid_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wstrb_o,
  input  logic                mem_ready_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic [1:0]          grant_o,
  output logic                err_o
);

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  state_t state_q, state_d;
  logic   last_q, last_d;
  logic   pick_idx, pick_any;
  logic   to_abort;
  logic   busy, own0, own1, done;
  logic [DATA_W-1:0] done_data;

  psram_arb_rr u_rr (
    .valid_i ({req1_valid_i, req0_valid_i}),
    .last_i  (last_q),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

`ifdef PSRAM_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  // Abort on the TIMEOUT-th BUSY cycle unless the memory completes in that same cycle.
  assign to_abort = (state_q != IDLE) && !mem_ready_i && (cnt_q == TO_LIM - 8'd1);

  // Busy-cycle counter: cleared while idle so it starts at zero on BUSY entry.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (!mem_ready_i && !to_abort) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Busy-cycle counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TO_LIM;
  assign to_abort       = 1'b0;
`endif

  // State and round-robin history registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= LAST_RST;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Next state: grant from IDLE, return to IDLE on completion or abort.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = pick_idx ? BUSY1 : BUSY0;
          last_d  = pick_idx;
        end
      end
      BUSY0, BUSY1: begin
        if (mem_ready_i || to_abort) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: payload mux from the owner, completion routed only to the owner.
  always_comb begin
    busy      = (state_q != IDLE);
    own0      = (state_q == BUSY0);
    own1      = (state_q == BUSY1);
    done      = busy && (mem_ready_i || to_abort);
    done_data = mem_ready_i ? mem_rdata_i : '1;

    mem_valid_o = busy;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wstrb_o = '0;
    if (own0) begin
      mem_addr_o  = req0_addr_i;
      mem_wdata_o = req0_wdata_i;
      mem_wstrb_o = req0_wstrb_i;
    end else if (own1) begin
      mem_addr_o  = req1_addr_i;
      mem_wdata_o = req1_wdata_i;
      mem_wstrb_o = req1_wstrb_i;
    end

    req0_ready_o = own0 && done;
    req1_ready_o = own1 && done;
    req0_rdata_o = (own0 && done) ? done_data : '0;
    req1_rdata_o = (own1 && done) ? done_data : '0;
    grant_o      = state_grant(state_q);
    err_o        = to_abort;
  end

endmodule

// File: tb/tb_psram_arb.sv
// tb/tb_psram_arb.sv - self-checking bench for psram_arb against a transaction-level model
module tb_psram_arb;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam int TLIM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          v0, v1, mrdy;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1, mrdata;
  logic [3:0]    s0, s1;
  logic          r0, r1, mvalid, err;
  logic [DW-1:0] rd0, rd1, mwdata;
  logic [AW-1:0] maddr;
  logic [3:0]    mwstrb;
  logic [1:0]    grant;

  int n_assert = 0;
  int n_fail   = 0;

  // model: current owner (-1 idle), last winner, busy cycles elapsed
  int m_owner;
  int m_last;
  int m_cnt;

  psram_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TLIM)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(v0), .req0_addr_i(a0), .req0_wdata_i(d0), .req0_wstrb_i(s0),
    .req0_ready_o(r0), .req0_rdata_o(rd0),
    .req1_valid_i(v1), .req1_addr_i(a1), .req1_wdata_i(d1), .req1_wstrb_i(s1),
    .req1_ready_o(r1), .req1_rdata_o(rd1),
    .mem_valid_o(mvalid), .mem_addr_o(maddr), .mem_wdata_o(mwdata), .mem_wstrb_o(mwstrb),
    .mem_ready_i(mrdy), .mem_rdata_i(mrdata),
    .grant_o(grant), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_timeout();
`ifdef PSRAM_ARB_TIMEOUT_EN
    return (m_owner >= 0) && !mrdy && (m_cnt == TLIM - 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 1;
    m_cnt   = 0;
  endtask

  // Compare every DUT output with what the model predicts for the present inputs.
  task automatic check_all();
    logic          to, dn;
    logic [DW-1:0] dd;
    to = m_timeout();
    dn = (m_owner >= 0) && (mrdy || to);
    dd = mrdy ? mrdata : {DW{1'b1}};
    chk("mem_valid", mvalid, m_owner >= 0);
    chk("mem_addr",  maddr,  m_owner == 0 ? a0 : m_owner == 1 ? a1 : '0);
    chk("mem_wdata", mwdata, m_owner == 0 ? d0 : m_owner == 1 ? d1 : '0);
    chk("mem_wstrb", mwstrb, m_owner == 0 ? s0 : m_owner == 1 ? s1 : '0);
    chk("req0_ready", r0, dn && m_owner == 0);
    chk("req1_ready", r1, dn && m_owner == 1);
    chk("req0_rdata", rd0, (dn && m_owner == 0) ? dd : '0);
    chk("req1_rdata", rd1, (dn && m_owner == 1) ? dd : '0);
    chk("grant", grant, m_owner < 0 ? 2'b00 : (m_owner == 0 ? 2'b01 : 2'b10));
    chk("err", err, to);
  endtask

  // Advance the model across one rising edge using the inputs held at that edge.
  task automatic model_step();
    logic dn;
    if (rst) begin
      model_reset();
    end else if (m_owner < 0) begin
      if (v0 && v1)  m_owner = (m_last == 0) ? 1 : 0;
      else if (v0)   m_owner = 0;
      else if (v1)   m_owner = 1;
      if (m_owner >= 0) m_last = m_owner;
      m_cnt = 0;
    end else begin
      dn = mrdy || m_timeout();
      if (dn) m_owner = -1;
      else    m_cnt++;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    check_all();
  endtask

  task automatic adv();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    adv();
    rst = 1'b0;
  endtask

  int order[$];
  logic [1:0] prev_grant;
  int busy_n;

  initial begin
    rst = 1'b1; v0 = 0; v1 = 0; mrdy = 0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0; s0 = '0; s1 = '0; mrdata = '0;
    model_reset();

    // reset state, with requests and memory activity present
    v0 = 1; v1 = 1; mrdy = 1; a0 = 24'h123456;
    sample();
    chk("rst_grant", grant, 2'b00);
    chk("rst_mem_valid", mvalid, 1'b0);
    adv();
    v0 = 0; v1 = 0; mrdy = 0; a0 = '0;

    // single read: valid at cycle 0, mem_valid at 1, ack at 6
    rst = 1'b0;
    v0 = 1; a0 = 24'h000010; s0 = 4'h0;
    sample();
    adv();
    sample();
    chk("rd_mem_valid_c1", mvalid, 1'b1);
    chk("rd_grant_c1", grant, 2'b01);
    chk("rd_addr_c1", maddr, 24'h000010);
    for (int k = 2; k <= 5; k++) begin
      adv();
      sample();
    end
    adv();
    mrdy = 1; mrdata = 32'hDEADBEEF;
    sample();
    chk("rd_ready_c6", r0, 1'b1);
    chk("rd_rdata_c6", rd0, 32'hDEADBEEF);
    adv();
    v0 = 0; mrdy = 0; mrdata = '0;
    sample();
    chk("rd_grant_after", grant, 2'b00);

    // conflict from reset release: req0 first, req1 on the IDLE cycle after
    rst = 1'b1; model_reset();
    v0 = 1; v1 = 1; a1 = 24'h0000A0;
    adv();
    rst = 1'b0;
    sample();
    adv();
    mrdy = 1; mrdata = 32'h11112222;
    sample();
    chk("cf_first_grant", grant, 2'b01);
    chk("cf_req0_ready", r0, 1'b1);
    adv();
    mrdy = 0;
    sample();
    chk("cf_idle_gap", grant, 2'b00);
    adv();
    sample();
    chk("cf_second_grant", grant, 2'b10);
    chk("cf_second_addr", maddr, 24'h0000A0);

    // fairness: both held valid, memory acks in the first BUSY cycle
    mrdy = 1;
    adv();
    mrdy = 0;
    sample();
    prev_grant = 2'b00;
    for (int c = 0; c < 40 && order.size() < 6; c++) begin
      adv();
      mrdy = mvalid;
      sample();
      if (grant != 2'b00 && prev_grant == 2'b00) order.push_back(grant == 2'b10 ? 1 : 0);
      prev_grant = grant;
    end
    chk("fair_count", order.size(), 6);
    for (int i = 0; i < 6 && i < order.size(); i++) chk($sformatf("fair_order%0d", i), order[i], i % 2);
    adv();
    v0 = 0; v1 = 0; mrdy = 0;
    sample();
    adv();

    // reset in BUSY1: outputs drop immediately, req1 re-granted after release
    v1 = 1; a1 = 24'h00BEEF;
    sample();
    adv();
    sample();
    chk("mr_busy1", grant, 2'b10);
    rst = 1'b1; model_reset();
    #1;
    chk("mr_grant_rst", grant, 2'b00);
    chk("mr_mem_valid_rst", mvalid, 1'b0);
    chk("mr_addr_rst", maddr, '0);
    sample();
    adv();
    rst = 1'b0;
    sample();
    adv();
    sample();
    chk("mr_regrant", grant, 2'b10);
    mrdy = 1;
    adv();
    v1 = 0; mrdy = 0;

    // stray mem_ready while idle
    mrdy = 1;
    sample();
    chk("stray_r0", r0, 1'b0);
    chk("stray_r1", r1, 1'b0);
    adv();
    mrdy = 0;
    sample();
    chk("stray_grant", grant, 2'b00);

`ifdef PSRAM_ARB_TIMEOUT_EN
    // timeout: memory never answers
    v0 = 1; a0 = 24'h000040;
    adv();
    busy_n = 1;
    sample();
    while (busy_n < TLIM) begin
      adv();
      busy_n++;
      sample();
    end
    chk("to_err", err, 1'b1);
    chk("to_ready", r0, 1'b1);
    chk("to_rdata", rd0, 32'hFFFFFFFF);
    adv();
    v0 = 0;
    sample();
    chk("to_mem_valid_after", mvalid, 1'b0);
`endif

    // randomized traffic checked cycle by cycle against the model
    for (int c = 0; c < 400; c++) begin
      adv();
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      mrdy = ($urandom_range(0, 2) == 0);
      a0 = AW'($urandom); a1 = AW'($urandom);
      d0 = $urandom; d1 = $urandom; mrdata = $urandom;
      s0 = 4'($urandom); s1 = 4'($urandom);
      sample();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
